// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Brief    : Pipeline hazard controller: load-use bubbles, memory-wait freeze
//            with timeout fault, taken-branch flush. Define HAZARD_PERF_CNT_EN
//            to build the saturating performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
  parameter int TIMEOUT = 64
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [4:0]  i_id_rs1,
  input  logic [4:0]  i_id_rs2,
  input  logic        i_id_use_rs1,
  input  logic        i_id_use_rs2,
  input  logic        i_id_branch_taken,
  input  logic [4:0]  i_exe_rd,
  input  logic        i_exe_mem2reg,
  input  logic        i_exe_wreg,
  input  logic        i_mem_req,
  input  logic        i_mem_ready,
  output logic        o_pc_stall,
  output logic        o_if_id_stall,
  output logic        o_id_exe_bubble,
  output logic        o_if_id_flush,
  output logic        o_pipe_freeze,
  output logic        o_fault,
  output logic [31:0] o_load_stall_cnt,
  output logic [31:0] o_mem_stall_cnt,
  output logic [31:0] o_flush_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FAULT    = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT);

  state_t     state;
  state_t     state_next;
  state_t     decode_state;
  logic [7:0] wait_cnt;
  logic [7:0] wait_cnt_next;
  logic       hz;
  logic       ms;

  assign hz = i_exe_mem2reg & i_exe_wreg & (i_exe_rd != 5'd0) &
              ((i_id_use_rs1 & (i_id_rs1 == i_exe_rd)) |
               (i_id_use_rs2 & (i_id_rs2 == i_exe_rd)));
  assign ms = i_mem_req & ~i_mem_ready;

  // Outputs seen during a reset cycle must decode as RUN, whatever the state.
  assign decode_state = i_reset ? RUN : state;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state    <= RUN;
      wait_cnt <= 8'd0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  always_comb begin
    state_next      = decode_state;
    wait_cnt_next   = wait_cnt;
    o_pc_stall      = 1'b0;
    o_if_id_stall   = 1'b0;
    o_id_exe_bubble = 1'b0;
    o_if_id_flush   = 1'b0;
    o_pipe_freeze   = 1'b0;
    o_fault         = 1'b0;
    case (decode_state)
      RUN: begin
        if (ms) begin
          o_pipe_freeze = 1'b1;
          o_pc_stall    = 1'b1;
          o_if_id_stall = 1'b1;
          state_next    = MEM_WAIT;
          wait_cnt_next = 8'd1;
        end else if (hz) begin
          o_pc_stall      = 1'b1;
          o_if_id_stall   = 1'b1;
          o_id_exe_bubble = 1'b1;
        end else if (i_id_branch_taken) begin
          o_if_id_flush = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (i_mem_ready) begin
          state_next    = RUN;
          wait_cnt_next = 8'd0;
        end else begin
          o_pipe_freeze = 1'b1;
          o_pc_stall    = 1'b1;
          o_if_id_stall = 1'b1;
          // The counter holds the number of wait cycles including this one.
          if (wait_cnt >= TIMEOUT_LIM) begin
            state_next = FAULT;
          end else begin
            wait_cnt_next = wait_cnt + 8'd1;
          end
        end
      end
      FAULT: begin
        o_pipe_freeze = 1'b1;
        o_pc_stall    = 1'b1;
        o_if_id_stall = 1'b1;
        o_fault       = 1'b1;
      end
      default: begin
        state_next    = RUN;
        wait_cnt_next = 8'd0;
      end
    endcase
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] load_stall_cnt;
  logic [31:0] mem_stall_cnt;
  logic [31:0] flush_cnt;

  // Bubble and flush are only raised in RUN; freeze outside FAULT marks a memory stall.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      load_stall_cnt <= 32'd0;
      mem_stall_cnt  <= 32'd0;
      flush_cnt      <= 32'd0;
    end else begin
      if (o_id_exe_bubble && (load_stall_cnt != 32'hFFFF_FFFF)) begin
        load_stall_cnt <= load_stall_cnt + 32'd1;
      end
      if (o_pipe_freeze && !o_fault && (mem_stall_cnt != 32'hFFFF_FFFF)) begin
        mem_stall_cnt <= mem_stall_cnt + 32'd1;
      end
      if (o_if_id_flush && (flush_cnt != 32'hFFFF_FFFF)) begin
        flush_cnt <= flush_cnt + 32'd1;
      end
    end
  end

  assign o_load_stall_cnt = load_stall_cnt;
  assign o_mem_stall_cnt  = mem_stall_cnt;
  assign o_flush_cnt      = flush_cnt;
`else
  assign o_load_stall_cnt = 32'd0;
  assign o_mem_stall_cnt  = 32'd0;
  assign o_flush_cnt      = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl
// Brief    : Directed scoreboard bench for hazard_ctrl (TIMEOUT = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

  logic        clk;
  logic        reset;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_use_rs1;
  logic        id_use_rs2;
  logic        id_branch_taken;
  logic [4:0]  exe_rd;
  logic        exe_mem2reg;
  logic        exe_wreg;
  logic        mem_req;
  logic        mem_ready;
  logic        pc_stall;
  logic        if_id_stall;
  logic        id_exe_bubble;
  logic        if_id_flush;
  logic        pipe_freeze;
  logic        fault;
  logic [31:0] load_stall_cnt;
  logic [31:0] mem_stall_cnt;
  logic [31:0] flush_cnt;

  hazard_ctrl #(.TIMEOUT(4)) dut (
    .i_clk             (clk),
    .i_reset           (reset),
    .i_id_rs1          (id_rs1),
    .i_id_rs2          (id_rs2),
    .i_id_use_rs1      (id_use_rs1),
    .i_id_use_rs2      (id_use_rs2),
    .i_id_branch_taken (id_branch_taken),
    .i_exe_rd          (exe_rd),
    .i_exe_mem2reg     (exe_mem2reg),
    .i_exe_wreg        (exe_wreg),
    .i_mem_req         (mem_req),
    .i_mem_ready       (mem_ready),
    .o_pc_stall        (pc_stall),
    .o_if_id_stall     (if_id_stall),
    .o_id_exe_bubble   (id_exe_bubble),
    .o_if_id_flush     (if_id_flush),
    .o_pipe_freeze     (pipe_freeze),
    .o_fault           (fault),
    .o_load_stall_cnt  (load_stall_cnt),
    .o_mem_stall_cnt   (mem_stall_cnt),
    .o_flush_cnt       (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output vector order: {pc_stall, if_id_stall, bubble, flush, freeze, fault}
  localparam logic [5:0] NONE   = 6'b000000;
  localparam logic [5:0] FRZ    = 6'b110010;
  localparam logic [5:0] HZB    = 6'b111000;
  localparam logic [5:0] FLS    = 6'b000100;
  localparam logic [5:0] FLT    = 6'b110011;

`ifdef HAZARD_PERF_CNT_EN
  localparam logic [31:0] CNT_MASK = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] CNT_MASK = 32'h0000_0000;
`endif

  typedef struct {
    string       tag;
    int          kind;
    logic [31:0] val;
  } sb_item_t;

  sb_item_t sb[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] observe(input int kind);
    case (kind)
      0: return {26'd0, pc_stall, if_id_stall, id_exe_bubble, if_id_flush, pipe_freeze, fault};
      1: return load_stall_cnt;
      2: return mem_stall_cnt;
      default: return flush_cnt;
    endcase
  endfunction

  task automatic drain();
    sb_item_t    e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.kind);
      checks++;
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [5:0] e);
    sb.push_back('{tag, 0, {26'd0, e}});
    #2;
    drain();
  endtask

  task automatic chk_cnt(input string tag, input int ld, input int msc, input int fl);
    sb.push_back('{{tag, "_ld"}, 1, 32'(ld) & CNT_MASK});
    sb.push_back('{{tag, "_ms"}, 2, 32'(msc) & CNT_MASK});
    sb.push_back('{{tag, "_fl"}, 3, 32'(fl) & CNT_MASK});
    drain();
  endtask

  task automatic idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    id_branch_taken = 1'b0; exe_rd = 5'd0; exe_mem2reg = 1'b0; exe_wreg = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic exe_load(input logic [4:0] rd);
    exe_mem2reg = 1'b1; exe_wreg = 1'b1; exe_rd = rd;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    // Reset cycle with a pending memory miss decodes as RUN
    @(negedge clk); mem_req = 1'b1;
    chk("rst_run_decode", FRZ);
    @(negedge clk); reset = 1'b0; idle();
    chk("reset_outs", NONE);
    chk_cnt("reset_cnt", 0, 0, 0);

    // Load-use on rs1: one bubble, then clear
    exe_load(5'd5); id_rs1 = 5'd5; id_use_rs1 = 1'b1; id_rs2 = 5'd7; id_use_rs2 = 1'b1;
    chk("hz_rs1", HZB);
    @(negedge clk); exe_mem2reg = 1'b0; exe_wreg = 1'b0; exe_rd = 5'd0;
    chk("hz_rs1_after", NONE);
    chk_cnt("hz_rs1_cnt", 1, 0, 0);

    // Load-use on rs2 only
    @(negedge clk); idle(); exe_load(5'd9); id_rs1 = 5'd3; id_use_rs1 = 1'b1;
    id_rs2 = 5'd9; id_use_rs2 = 1'b1;
    chk("hz_rs2", HZB);
    @(negedge clk); id_use_rs2 = 1'b0;
    chk("hz_rs2_unused", NONE);

    // Loads to x0 and non-load producers never stall
    @(negedge clk); idle(); exe_load(5'd0); id_use_rs1 = 1'b1; id_use_rs2 = 1'b1;
    chk("x0_load", NONE);
    @(negedge clk); idle(); exe_wreg = 1'b1; exe_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
    chk("nonload", NONE);
    @(negedge clk); idle(); mem_ready = 1'b1;
    chk("ready_no_req", NONE);

    // Hazard beats branch; branch re-presented next cycle flushes
    @(negedge clk); idle(); exe_load(5'd12); id_rs2 = 5'd12; id_use_rs2 = 1'b1; id_branch_taken = 1'b1;
    chk("hz_branch", HZB);
    @(negedge clk); exe_mem2reg = 1'b0; exe_wreg = 1'b0; exe_rd = 5'd0;
    chk("branch_flush", FLS);
    @(negedge clk); idle();
    chk("post_flush", NONE);
    chk_cnt("flush_cnt", 3, 0, 1);

    // Memory wait: RUN entry + 3 wait cycles, then ready
    mem_req = 1'b1;
    chk("ms_entry", FRZ);
    @(negedge clk); chk("mw1", FRZ);
    @(negedge clk); id_branch_taken = 1'b1;
    chk("mw2_branch_ignored", FRZ);
    @(negedge clk); id_branch_taken = 1'b0;
    chk("mw3", FRZ);
    @(negedge clk); mem_ready = 1'b1;
    chk("mw_ready", NONE);
    @(negedge clk); idle();
    chk("after_mw", NONE);
    chk_cnt("mw_cnt", 3, 4, 1);

    // Reset in the 2nd wait cycle returns to RUN
    mem_req = 1'b1;
    chk("ms2_entry", FRZ);
    @(negedge clk); chk("ms2_mw1", FRZ);
    @(negedge clk); reset = 1'b1;
    chk("ms2_rst_decode", FRZ);
    @(negedge clk); reset = 1'b0; idle();
    chk("ms2_after_rst", NONE);
    chk_cnt("ms2_rst_cnt", 0, 0, 0);

    // Timeout: entry + 4 wait cycles, then FAULT until reset
    mem_req = 1'b1;
    chk("to_entry", FRZ);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk); chk($sformatf("to_mw%0d", i), FRZ);
    end
    @(negedge clk); chk("fault_entered", FLT);
    @(negedge clk); mem_req = 1'b0; mem_ready = 1'b1;
    chk("fault_sticky", FLT);
    chk_cnt("fault_cnt", 0, 5, 0);
    @(negedge clk); idle(); reset = 1'b1;
    chk("fault_rst_decode", NONE);
    @(negedge clk); reset = 1'b0;
    chk("fault_cleared", NONE);
    chk_cnt("fault_cleared_cnt", 0, 0, 0);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
